// File: rtl/boreal_mem_arbiter.sv
// Round-robin arbiter for port B of the Boreal weight/LUT memory.
// It arbitrates between the host configuration path and the learning engine, and returns reads with a fixed 2-edge latency.
module boreal_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  output logic                  h_gnt,
  output logic                  h_rvalid,
  output logic [DATA_WIDTH-1:0] h_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  input  logic                  learn_en,
  output logic                  mem_we_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_din_b,
  input  logic [DATA_WIDTH-1:0] mem_dout_b,
  output logic [CNT_WIDTH-1:0]  contention_cnt
);

  typedef enum logic {
    OWN_HOST  = 1'b0,
    OWN_LEARN = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  logic                  h_elig;
  logic                  l_elig;
  logic                  both_elig;
  logic                  accept;
  owner_e                winner;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  owner_e                last_gnt;
  tag_t                  tag_issue;
  tag_t                  tag_ret;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    h_elig    = h_req;
    l_elig    = l_req & learn_en;
    both_elig = h_elig & l_elig;
    // When both requesters are eligible, the one that did not win last time gets the grant.
    h_gnt     = !rst && h_elig && (!l_elig || (last_gnt == OWN_LEARN));
    l_gnt     = !rst && l_elig && (!h_elig || (last_gnt == OWN_HOST));
    accept    = h_gnt | l_gnt;
    winner    = OWN_HOST;
    win_we    = h_we;
    win_addr  = h_addr;
    win_wdata = h_wdata;
    if (l_gnt) begin
      winner    = OWN_LEARN;
      win_we    = l_we;
      win_addr  = l_addr;
      win_wdata = l_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt       <= OWN_LEARN;
      mem_we_b       <= 1'b0;
      mem_addr_b     <= '0;
      mem_din_b      <= '0;
      tag_issue      <= '{valid: 1'b0, owner: OWN_HOST};
      tag_ret        <= '{valid: 1'b0, owner: OWN_HOST};
      contention_cnt <= '0;
    end else begin
      mem_we_b <= 1'b0;
      if (accept) begin
        last_gnt   <= winner;
        mem_we_b   <= win_we;
        mem_addr_b <= win_addr;
        mem_din_b  <= win_wdata;
      end
      // Only reads launch a valid tag. The tag then follows the memory's one-cycle read register.
      tag_issue <= '{valid: accept & ~win_we, owner: winner};
      tag_ret   <= tag_issue;
      if (both_elig && (contention_cnt != '1)) begin
        contention_cnt <= contention_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    h_rvalid = tag_ret.valid && (tag_ret.owner == OWN_HOST);
    l_rvalid = tag_ret.valid && (tag_ret.owner == OWN_LEARN);
    h_rdata  = mem_dout_b;
    l_rdata  = mem_dout_b;
  end

endmodule

// File: tb/tb_boreal_mem_arbiter.sv
// Directed bench for boreal_mem_arbiter driving a registered RAM model.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_boreal_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          h_req, h_we, l_req, l_we, learn_en;
  logic [AW-1:0] h_addr, l_addr;
  logic [DW-1:0] h_wdata, l_wdata;
  logic          h_gnt, h_rvalid, l_gnt, l_rvalid, mem_we_b;
  logic [DW-1:0] h_rdata, l_rdata, mem_din_b;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_dout_b = '0;
  logic [15:0]   contention_cnt;

  logic          s_h_gnt, s_h_rvalid, s_l_gnt, s_l_rvalid, s_mem_we_b;
  logic [DW-1:0] s_h_rdata, s_l_rdata, s_mem_din_b;
  logic [AW-1:0] s_mem_addr_b;
  logic [3:0]    s_cnt;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  boreal_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .learn_en(learn_en),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_din_b(mem_din_b),
    .mem_dout_b(mem_dout_b), .contention_cnt(contention_cnt)
  );

  boreal_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(s_h_gnt), .h_rvalid(s_h_rvalid), .h_rdata(s_h_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(s_l_gnt), .l_rvalid(s_l_rvalid), .l_rdata(s_l_rdata),
    .learn_en(learn_en),
    .mem_we_b(s_mem_we_b), .mem_addr_b(s_mem_addr_b), .mem_din_b(s_mem_din_b),
    .mem_dout_b(mem_dout_b), .contention_cnt(s_cnt)
  );

  // Registered RAM model with read-before-write behaviour.
  always @(posedge clk) begin
    if (mem_we_b) mem[mem_addr_b] <= mem_din_b;
    mem_dout_b <= mem[mem_addr_b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the negedge before an edge, apply idle inputs, and let the combinational logic settle.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_req = 1'b0;
      l_req = 1'b0;
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    mem[3] = 32'h33;
    rst = 1'b1; learn_en = 1'b1;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

    // Reset state. A request made while rst is high must not be granted.
    @(negedge clk); @(negedge clk);
    h_req = 1'b1; #1;
    check("rst_h_gnt", h_gnt, 0);
    check("rst_we", mem_we_b, 0);
    check("rst_addr", mem_addr_b, 0);
    check("rst_din", mem_din_b, 0);
    check("rst_rvalid", {h_rvalid, l_rvalid}, 0);
    check("rst_cnt", contention_cnt, 0);
    @(negedge clk); rst = 1'b0; h_req = 1'b0; #1;

    // Contention: the host wins first, then grants alternate H,L,H,L.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      h_req = 1'b1; h_we = 1'b0; h_addr = 10'd10;
      l_req = 1'b1; l_we = 1'b0; l_addr = 10'd20; #1;
      check($sformatf("cont_h_gnt%0d", k), h_gnt, (k % 2 == 0));
      check($sformatf("cont_l_gnt%0d", k), l_gnt, (k % 2 == 1));
      if (k > 0) check($sformatf("cont_addr%0d", k), mem_addr_b, (k % 2 == 1) ? 10 : 20);
    end
    @(negedge clk); h_req = 1'b0; l_req = 1'b0; #1;
    check("cont_addr4", mem_addr_b, 20);
    check("cont_cnt", contention_cnt, 4);
    idle(3);

    // Host write 0xDEADBEEF to address 5, then read it back on the next cycle.
    @(negedge clk);
    h_req = 1'b1; h_we = 1'b1; h_addr = 10'd5; h_wdata = 32'hDEADBEEF; #1;
    check("hw_gnt", h_gnt, 1);
    @(negedge clk); h_we = 1'b0; #1;
    check("hr_gnt", h_gnt, 1);
    check("hw_we", mem_we_b, 1);
    check("hw_addr", mem_addr_b, 5);
    check("hw_din", mem_din_b, 32'hDEADBEEF);
    @(negedge clk); h_req = 1'b0; #1;
    check("hr_we", mem_we_b, 0);
    check("hr_early", h_rvalid, 0);
    @(negedge clk); #1;
    check("hr_rvalid", h_rvalid, 1);
    check("hr_rdata", h_rdata, 32'hDEADBEEF);
    check("hr_l_rvalid", l_rvalid, 0);
    @(negedge clk); #1;
    check("hr_rvalid_1cyc", h_rvalid, 0);

    // Gate: while learn_en=0, learner requests are masked. Raising learn_en grants on that same cycle.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      learn_en = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 10'd7; l_wdata = 32'h77; #1;
      check($sformatf("gate_l_gnt%0d", k), l_gnt, 0);
      check($sformatf("gate_we%0d", k), mem_we_b, 0);
    end
    @(negedge clk); learn_en = 1'b1; #1;
    check("gate_open_gnt", l_gnt, 1);
    @(negedge clk); l_req = 1'b0; #1;
    check("gate_we_issue", mem_we_b, 1);
    check("gate_addr", mem_addr_b, 7);
    idle(2);

    // Back-to-back learner reads of addresses 1, 2, 3.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      l_req = 1'b1; l_we = 1'b0; l_addr = AW'(k); #1;
      check($sformatf("b2b_gnt%0d", k), l_gnt, 1);
      if (k == 3) begin
        check("b2b_rv1", l_rvalid, 1);
        check("b2b_rd1", l_rdata, 32'h11);
      end
    end
    @(negedge clk); l_req = 1'b0; #1;
    check("b2b_rv2", l_rvalid, 1);
    check("b2b_rd2", l_rdata, 32'h22);
    @(negedge clk); #1;
    check("b2b_rv3", l_rvalid, 1);
    check("b2b_rd3", l_rdata, 32'h33);
    check("b2b_h_rvalid", h_rvalid, 0);
    @(negedge clk); #1;
    check("b2b_rv_end", l_rvalid, 0);

    // Reset mid-read: the accepted host read must never produce h_rvalid.
    @(negedge clk); h_req = 1'b1; h_we = 1'b0; h_addr = 10'd5; #1;
    check("mr_gnt", h_gnt, 1);
    @(negedge clk); rst = 1'b1; #1;
    check("mr_gnt_in_rst", h_gnt, 0);
    @(negedge clk); rst = 1'b0; h_req = 1'b0; #1;
    check("mr_rvalid", {h_rvalid, l_rvalid}, 0);
    check("mr_we", mem_we_b, 0);
    check("mr_addr", mem_addr_b, 0);
    check("mr_din", mem_din_b, 0);
    check("mr_cnt", contention_cnt, 0);
    @(negedge clk); #1;
    check("mr_rvalid_late", h_rvalid, 0);

    // Saturation: 20 contended cycles. The 4-bit counter sticks at 0xF; the wide one reads 20.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      h_req = 1'b1; h_we = 1'b1; h_addr = 10'd40;
      l_req = 1'b1; l_we = 1'b1; l_addr = 10'd41; #1;
      if (k == 0) check("sat_first_host", h_gnt, 1);
    end
    @(negedge clk); h_req = 1'b0; l_req = 1'b0; #1;
    check("sat_small", s_cnt, 4'hF);
    check("sat_wide", contention_cnt, 20);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boreal_mem_arbiter.md
Name: boreal_mem_arbiter

Overview:
Arbitrates the read/write port (port B) of the Boreal weight/LUT memory between two requesters: the host/UART configuration path and the on-chip learning engine. It applies round-robin fairness and a learning-enable gate. Accepted accesses are registered onto the memory port, and read data is returned to the originating requester with fixed latency. The inference port (port A) is not touched by this block.

Parameters:
ADDR_WIDTH, 10, memory address width; must match the weight memory.
DATA_WIDTH, 32, memory data width.
CNT_WIDTH, 16, width of the saturating contention counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
h_req  input  1  host access request
h_we  input  1  host write (1) / read (0)
h_addr  input  ADDR_WIDTH  host address
h_wdata  input  DATA_WIDTH  host write data
h_gnt  output  1  host request accepted this cycle (combinational)
h_rvalid  output  1  host read data valid
h_rdata  output  DATA_WIDTH  host read data
l_req  input  1  learner access request
l_we  input  1  learner write / read
l_addr  input  ADDR_WIDTH  learner address
l_wdata  input  DATA_WIDTH  learner write data
l_gnt  output  1  learner request accepted this cycle (combinational)
l_rvalid  output  1  learner read data valid
l_rdata  output  DATA_WIDTH  learner read data
learn_en  input  1  when 0, learner requests are masked
mem_we_b  output  1  memory port B write enable
mem_addr_b  output  ADDR_WIDTH  memory port B address
mem_din_b  output  DATA_WIDTH  memory port B write data
mem_dout_b  input  DATA_WIDTH  memory port B read data (registered inside memory)
contention_cnt  output  CNT_WIDTH  cycles in which both eligible requesters were active

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Eligibility:
  - Host is eligible when h_req=1.
  - Learner is eligible when l_req=1 and learn_en=1.
- Grant rules (combinational, at most one grant per cycle):
  - Only one requester eligible: that requester is granted.
  - Both eligible: grant goes to the requester NOT recorded in the last_gnt register.
- last_gnt register:
  - Updated on every grant to the granted requester.
  - Reset value is "learner", so the host wins the first contention.
- Acceptance: a transfer is accepted on the clock edge where req and gnt are both 1. An accepted requester may change addr/data/we on the following cycle.
- Issue stage (registered): on an accepting edge E0, mem_addr_b, mem_din_b and mem_we_b load from the winner.
  - mem_we_b is 1 for writes, 0 for reads.
  - On an edge with no acceptance, mem_we_b is cleared to 0; mem_addr_b and mem_din_b hold their values.
  - The memory performs the access at E1.
- Read return:
  - A 2-deep tag pipeline tracks {valid, owner}. Only reads set valid.
  - The tag launched at E0 reaches the output at E1.
  - Exactly one of h_rvalid/l_rvalid is 1 for exactly one cycle after E1.
  - Read latency is therefore 2 edges from acceptance.
- Read data: h_rdata and l_rdata are both driven directly from mem_dout_b. Each is qualified only by its own rvalid.
- Writes generate no rvalid.
- Throughput: back-to-back accepts every cycle are allowed; reads and writes interleave freely.
- Ordering: program order on port B is preserved. A read accepted the cycle after a write to the same address returns the new data, because the write lands at E1 and the read at E2.
- learn_en deasserted:
  - l_gnt is forced to 0 from that same cycle.
  - Learner reads already accepted still return l_rvalid.
  - Learner writes already issued still complete.
- contention_cnt:
  - Increments on every cycle where both requesters are eligible.
  - Saturates at all-ones.
  - Cleared only by rst.
- Reset values (rst=1 at an edge):
  - mem_we_b=0, mem_addr_b=0, mem_din_b=0.
  - Tag pipeline cleared, so h_rvalid=0 and l_rvalid=0.
  - last_gnt=learner, contention_cnt=0.
  - h_gnt and l_gnt are forced to 0 while rst=1.
  - Reads in flight at reset are dropped: no rvalid is ever produced for them.
  - A write issued on the edge before rst still completes in memory.
- Requester contract: h_we, addr and data must be stable while req=1 and gnt=0. Dropping req before grant is legal.

Test Plan:
- Host write then read: write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle → h_gnt=1 in both cycles; h_rvalid=1 exactly 2 edges after the read accept; h_rdata=0xDEADBEEF; l_rvalid stays 0.
- Contention: h_req=l_req=1 held for 4 cycles with learn_en=1 → grants alternate H,L,H,L; contention_cnt=4; mem_addr_b sequence follows the grant order.
- Gate: learn_en=0 with l_req=1 for 10 cycles → l_gnt=0 throughout and mem_we_b=0. Then raise learn_en → l_gnt=1 on that cycle.
- Back-to-back reads: learner reads addrs 1,2,3 on consecutive cycles (preloaded 0x11,0x22,0x33) → l_rvalid high for 3 consecutive cycles, data 0x11,0x22,0x33 in order.
- Reset mid-read: host read accepted, rst asserted on the next edge → no h_rvalid; all outputs at reset values; contention_cnt=0.
- Saturation: CNT_WIDTH=4, contend for 20 cycles → contention_cnt sticks at 0xF.
